// File: rtl/debug_tx_serializer_pkg.sv
// Shared constants and types for the debug dump serializer.
// Header byte values are only used when DEBUG_TX_HEADER_EN is defined.
package debug_pkg;

    localparam int unsigned NB_DATA   = 8;
    localparam int unsigned NB_32     = 32;
    localparam int unsigned NB_IF_ID  = 64;
    localparam int unsigned NB_ID_EX  = 168;
    localparam int unsigned NB_EX_MEM = 88;
    localparam int unsigned NB_MEM_WB = 80;

    localparam int unsigned NB_LATCHES  = NB_IF_ID + NB_ID_EX + NB_EX_MEM + NB_MEM_WB;
    localparam int unsigned LATCH_BYTES = (NB_LATCHES + NB_DATA - 1) / NB_DATA;
    localparam int unsigned NB_SHIFT    = LATCH_BYTES * NB_DATA;
    localparam int unsigned WORD_BYTES  = NB_32 / NB_DATA;
    localparam int unsigned CNT_W       = $clog2(LATCH_BYTES + 1);
    localparam int unsigned IDX_W       = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StReq,
        StCapture,
        StSend,
        StWaitTx,
        StNext,
        StFinish
    } state_e;

    typedef enum logic [1:0] {
        SelLatches = 2'b00,
        SelRegs    = 2'b01,
        SelMem     = 2'b10,
        SelAll     = 2'b11
    } sel_e;

    localparam logic [NB_DATA-1:0] HDR_LATCHES = 8'hA1;
    localparam logic [NB_DATA-1:0] HDR_REGS    = 8'hA2;
    localparam logic [NB_DATA-1:0] HDR_MEM     = 8'hA3;

    function automatic logic [NB_DATA-1:0] hdr_byte(sel_e sec);
        case (sec)
            SelRegs: return HDR_REGS;
            SelMem:  return HDR_MEM;
            default: return HDR_LATCHES;
        endcase
    endfunction

endpackage

// File: rtl/debug_tx_serializer_if.sv
// Byte link between the dump serializer and the UART transmitter.
interface debug_tx_serializer_if;
    import debug_pkg::*;

    logic               tx_start;
    logic [NB_DATA-1:0] data;
    logic               tx_done;

    modport master (output tx_start, output data, input tx_done);
    modport slave  (input tx_start, input data, output tx_done);

endinterface

// File: rtl/debug_tx_serializer_tx_byte_handshake.sv
// One-byte start/done handshake towards the UART TX: registered start pulse,
// byte held until the transmitter reports completion.
module tx_byte_handshake
    import debug_pkg::*;
(
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_send,
    input  logic [NB_DATA-1:0] i_byte,
    debug_tx_serializer_if.master tx,
    output logic               o_byte_ack
);

    logic               start_q, start_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic               wait_q, wait_d;

    always_comb begin
        start_d = i_send;
        data_d  = data_q;
        wait_d  = wait_q;
        if (i_send) begin
            data_d = i_byte;
            wait_d = 1'b1;
        end else if (wait_q && tx.tx_done) begin
            wait_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            start_q <= 1'b0;
            data_q  <= '0;
            wait_q  <= 1'b0;
        end else begin
            start_q <= start_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
        end
    end

    // A done pulse only counts while a byte is actually outstanding.
    assign o_byte_ack  = wait_q && tx.tx_done;
    assign tx.tx_start = start_q;
    assign tx.data     = data_q;

endmodule

// File: rtl/debug_tx_serializer.sv
// Debug dump sequencer: latch snapshot, register and memory walks streamed MSB first.
// Define DEBUG_TX_HEADER_EN to prefix each section with a 0xA1/0xA2/0xA3 header byte.
module debug_tx_serializer
    import debug_pkg::*;
#(
    parameter int unsigned N_REGS      = 32,
    parameter int unsigned N_MEM_WORDS = 32
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_send,
    input  logic [1:0]           i_sel,
    input  logic [NB_IF_ID-1:0]  i_if_id,
    input  logic [NB_ID_EX-1:0]  i_id_ex,
    input  logic [NB_EX_MEM-1:0] i_ex_mem,
    input  logic [NB_MEM_WB-1:0] i_mem_wb,
    output logic [4:0]           o_reg_addr,
    input  logic [NB_32-1:0]     i_reg_data,
    output logic [NB_32-1:0]     o_mem_addr,
    input  logic [NB_32-1:0]     i_mem_data,
    debug_tx_serializer_if.master tx,
    output logic                 o_busy,
    output logic                 o_done
);

    state_e              state_q, state_d;
    sel_e                sel_q, sel_d;
    sel_e                sec_q, sec_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NB_SHIFT-1:0] shreg_q, shreg_d;
`ifdef DEBUG_TX_HEADER_EN
    logic                hdr_q, hdr_d;
`endif

    logic byte_ack;
    logic enter;
    sel_e enter_sec;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        sec_d     = sec_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
`ifdef DEBUG_TX_HEADER_EN
        hdr_d     = hdr_q;
`endif
        enter     = 1'b0;
        enter_sec = SelLatches;

        case (state_q)
            StIdle: begin
                if (i_send) begin
                    sel_d     = sel_e'(i_sel);
                    enter     = 1'b1;
                    enter_sec = (sel_e'(i_sel) == SelAll) ? SelLatches : sel_e'(i_sel);
                end
            end
            StLoad: begin
                shreg_d                 = '0;
                shreg_d[NB_LATCHES-1:0] = {i_if_id, i_id_ex, i_ex_mem, i_mem_wb};
                cnt_d                   = CNT_W'(LATCH_BYTES);
                state_d                 = StSend;
            end
            StReq: state_d = StCapture;
            StCapture: begin
                shreg_d                       = '0;
                shreg_d[NB_SHIFT-1 -: NB_32]  = (sec_q == SelRegs) ? i_reg_data : i_mem_data;
                cnt_d                         = CNT_W'(WORD_BYTES);
                state_d                       = StSend;
            end
            StSend: state_d = StWaitTx;
            StWaitTx: begin
                if (byte_ack) begin
                    shreg_d = shreg_q << NB_DATA;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = StNext;
`ifdef DEBUG_TX_HEADER_EN
                        // Header sent: start the section body without bumping the index.
                        if (hdr_q) begin
                            hdr_d   = 1'b0;
                            state_d = (sec_q == SelLatches) ? StLoad : StReq;
                        end
`endif
                    end else begin
                        state_d = StSend;
                    end
                end
            end
            StNext: begin
                state_d = StFinish;
                case (sec_q)
                    SelLatches: begin
                        if (sel_q == SelAll) begin
                            enter     = 1'b1;
                            enter_sec = SelRegs;
                        end
                    end
                    SelRegs: begin
                        if (idx_q != IDX_W'(N_REGS - 1)) begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = StReq;
                        end else if (sel_q == SelAll) begin
                            enter     = 1'b1;
                            enter_sec = SelMem;
                        end
                    end
                    SelMem: begin
                        if (idx_q != IDX_W'(N_MEM_WORDS - 1)) begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = StReq;
                        end
                    end
                    default: state_d = StFinish;
                endcase
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (enter) begin
            sec_d = enter_sec;
            idx_d = '0;
`ifdef DEBUG_TX_HEADER_EN
            shreg_d                        = '0;
            shreg_d[NB_SHIFT-1 -: NB_DATA] = hdr_byte(enter_sec);
            cnt_d                          = CNT_W'(1);
            hdr_d                          = 1'b1;
            state_d                        = StSend;
`else
            state_d = (enter_sec == SelLatches) ? StLoad : StReq;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            sel_q   <= SelLatches;
            sec_q   <= SelLatches;
            idx_q   <= '0;
            cnt_q   <= '0;
            shreg_q <= '0;
`ifdef DEBUG_TX_HEADER_EN
            hdr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            sec_q   <= sec_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
`ifdef DEBUG_TX_HEADER_EN
            hdr_q   <= hdr_d;
`endif
        end
    end

    assign o_busy = (state_q != StIdle) && (state_q != StFinish);
    assign o_done = (state_q == StFinish);

    // Addresses follow the word index, so they stay put from REQ through CAPTURE.
    assign o_reg_addr = (o_busy && sec_q == SelRegs) ? idx_q[4:0] : '0;
    assign o_mem_addr = (o_busy && sec_q == SelMem) ? NB_32'({idx_q, 2'b00}) : '0;

    tx_byte_handshake u_handshake (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_send     (state_q == StSend),
        .i_byte     (shreg_q[NB_SHIFT-1 -: NB_DATA]),
        .tx         (tx),
        .o_byte_ack (byte_ack)
    );

endmodule

// File: tb/tb_debug_tx_serializer.sv
// Directed bench for debug_tx_serializer with a UART TX ack model and reg/mem models.
module tb_debug_tx_serializer;
    import debug_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         i_rst, i_send;
    logic [1:0]   i_sel;
    logic [399:0] lat;
    logic [63:0]  if_id;
    logic [167:0] id_ex;
    logic [87:0]  ex_mem;
    logic [79:0]  mem_wb;
    logic [4:0]   reg_addr;
    logic [31:0]  reg_data, mem_addr, mem_data;
    logic         busy, done;

    debug_tx_serializer_if tx_if();

    logic model_done = 1'b0, spur_done = 1'b0, idle_spur = 1'b0;
    bit   spur_en = 1'b0;
    assign tx_if.tx_done = model_done | spur_done | idle_spur;

    assign if_id  = lat[399:336];
    assign id_ex  = lat[335:168];
    assign ex_mem = lat[167:80];
    assign mem_wb = lat[79:0];

    assign reg_data = 32'h0000_0100 * {27'd0, reg_addr} + {27'd0, reg_addr};
    always @(posedge clk)
        mem_data <= {16'hC0DE, 3'd0, mem_addr[6:2], 8'd255 - {3'd0, mem_addr[6:2]}};

    debug_tx_serializer dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_send     (i_send),
        .i_sel      (i_sel),
        .i_if_id    (if_id),
        .i_id_ex    (id_ex),
        .i_ex_mem   (ex_mem),
        .i_mem_wb   (mem_wb),
        .o_reg_addr (reg_addr),
        .i_reg_data (reg_data),
        .o_mem_addr (mem_addr),
        .i_mem_data (mem_data),
        .tx         (tx_if),
        .o_busy     (busy),
        .o_done     (done)
    );

    int n_cmp = 0, n_err = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int n_start = 0, n_done = 0, hold_err = 0, addr_chg = 0, addr_bad = 0;
    logic [31:0] prev_addr = '0;
    bit pending = 1'b0;
    int tx_wait = 0;
    logic [7:0] cur_byte = '0;

    // UART TX model: acks each byte 10 cycles after its start pulse.
    always @(negedge clk) begin
        if (i_rst) begin
            pending    <= 1'b0;
            model_done <= 1'b0;
            spur_done  <= 1'b0;
        end else begin
            spur_done  <= model_done && spur_en;
            model_done <= 1'b0;
            if (tx_if.tx_start) begin
                got_q.push_back(tx_if.data);
                cur_byte <= tx_if.data;
                n_start  <= n_start + 1;
                pending  <= 1'b1;
                tx_wait  <= 9;
            end else if (pending) begin
                if (tx_if.data != cur_byte) hold_err <= hold_err + 1;
                if (tx_wait == 0) begin
                    model_done <= 1'b1;
                    pending    <= 1'b0;
                end else begin
                    tx_wait <= tx_wait - 1;
                end
            end
            if (done) n_done <= n_done + 1;
        end
        if (!busy) begin
            prev_addr <= '0;
        end else if (mem_addr != prev_addr) begin
            addr_chg  <= addr_chg + 1;
            if (mem_addr != prev_addr + 32'd4) addr_bad <= addr_bad + 1;
            prev_addr <= mem_addr;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_sec(input int sec);
`ifdef DEBUG_TX_HEADER_EN
        exp_q.push_back(8'(8'hA1 + sec));
`endif
        case (sec)
            0: for (int k = 0; k < 50; k++) exp_q.push_back(8'(k + 1));
            1: for (int r = 0; r < 32; r++) begin
                exp_q.push_back(8'h00);
                exp_q.push_back(8'h00);
                exp_q.push_back(8'(r));
                exp_q.push_back(8'(r));
            end
            default: for (int w = 0; w < 32; w++) begin
                exp_q.push_back(8'hC0);
                exp_q.push_back(8'hDE);
                exp_q.push_back(8'(w));
                exp_q.push_back(8'(255 - w));
            end
        endcase
    endtask

    task automatic run_dump(input logic [1:0] sel, input int resend_at, input string tag,
                            output int base);
        int d0, h0, cyc;
        exp_q.delete();
        if (sel == 2'b11) begin
            add_sec(0);
            add_sec(1);
            add_sec(2);
        end else begin
            add_sec(int'(sel));
        end
        base = got_q.size();
        d0   = n_done;
        h0   = hold_err;
        @(negedge clk);
        i_sel  = sel;
        i_send = 1'b1;
        @(negedge clk);
        i_send = 1'b0;
        i_sel  = ~sel;
        cyc    = 0;
        while (n_done == d0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            i_send = (cyc == resend_at);
        end
        i_send = 1'b0;
        check_eq({tag, " finished"}, 32'(cyc < 20000), 32'd1);
        repeat (15) @(negedge clk);
        check_eq({tag, " byte count"}, 32'(got_q.size() - base), 32'(exp_q.size()));
        check_eq({tag, " done pulses"}, 32'(n_done - d0), 32'd1);
        check_eq({tag, " busy after"}, 32'(busy), 32'd0);
        check_eq({tag, " data hold"}, 32'(hold_err - h0), 32'd0);
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < got_q.size())
                check_eq($sformatf("%s byte%0d", tag, i), 32'(got_q[base + i]), 32'(exp_q[i]));
    endtask

    initial begin
        int base, a0, b0, s0, s1, cyc;
        for (int k = 0; k < 50; k++) lat[399 - 8 * k -: 8] = 8'(k + 1);
        i_rst  = 1'b1;
        i_send = 1'b0;
        i_sel  = 2'b00;
        repeat (3) @(negedge clk);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);
        check_eq("reset tx_start", 32'(tx_if.tx_start), 32'd0);
        check_eq("reset data", 32'(tx_if.data), 32'd0);
        check_eq("reset reg_addr", 32'(reg_addr), 32'd0);
        check_eq("reset mem_addr", mem_addr, 32'd0);
        i_rst = 1'b0;

        // Spurious done while idle.
        s0 = n_start;
        idle_spur = 1'b1;
        repeat (3) @(negedge clk);
        idle_spur = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("idle spur starts", 32'(n_start - s0), 32'd0);
        check_eq("idle spur busy", 32'(busy), 32'd0);

        run_dump(2'b00, 0, "lat", base);

        run_dump(2'b01, 0, "reg", base);
        check_eq("reg5 b0", 32'(got_q[base + 20]), 32'h00);
        check_eq("reg5 b1", 32'(got_q[base + 21]), 32'h00);
        check_eq("reg5 b2", 32'(got_q[base + 22]), 32'h05);
        check_eq("reg5 b3", 32'(got_q[base + 23]), 32'h05);

        // Memory dump with an extra done pulse landing in every SEND cycle.
        a0 = addr_chg;
        b0 = addr_bad;
        spur_en = 1'b1;
        run_dump(2'b10, 0, "mem", base);
        spur_en = 1'b0;
        check_eq("mem addr steps", 32'(addr_chg - a0), 32'd31);
        check_eq("mem addr stride", 32'(addr_bad - b0), 32'd0);

        run_dump(2'b11, 300, "all", base);

        // Reset during byte 20 of a register dump.
        s0 = n_start;
        @(negedge clk);
        i_sel  = 2'b01;
        i_send = 1'b1;
        @(negedge clk);
        i_send = 1'b0;
        cyc    = 0;
        while (n_start < s0 + 20 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("rst wait byte20", 32'(cyc < 2000), 32'd1);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst tx_start", 32'(tx_if.tx_start), 32'd0);
        check_eq("rst data", 32'(tx_if.data), 32'd0);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst done", 32'(done), 32'd0);
        check_eq("rst reg_addr", 32'(reg_addr), 32'd0);
        @(negedge clk);
        i_rst = 1'b0;
        s1 = n_start;
        repeat (40) @(negedge clk);
        check_eq("rst no restart", 32'(n_start - s1), 32'd0);

        run_dump(2'b01, 0, "reg2", base);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
